uart_rx_axis: RTL and testbench

- Receive-side counterpart to the AXI-Stream-to-UART transmit path: deserialises 8N1 UART frames from a serial line into bytes.
- Buffers received bytes in a small FIFO and presents them as an AXI-Stream master.
- Marks packet boundaries (last) from idle gaps on the line.
- Sits at the far end of the UART link, feeding downstream stream logic; it is the reader for the transmitter's writer.

---
 rtl/uart_rx_axis.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_axis.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver feeding an AXI-Stream master through a small FIFO.
// Idle gaps on the line close packets: the last byte before the gap carries m_axis_last.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | line idle, waiting for a falling edge on rxs
//   S_START | timing to mid start bit, rejects glitches shorter than half a bit
//   S_DATA  | sampling 8 data bits LSB first, one per bit period
//   S_STOP  | timing to mid stop bit, then back to idle
module uart_rx_axis #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int IDLE_BITS    = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [7:0]                    m_axis_data,
    output logic                          m_axis_valid,
    output logic                          m_axis_last,
    input  logic                          m_axis_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta, rxs;
    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_tmr;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [7:0]        pend_data;
    logic              pend_valid;
    logic [IDLE_W-1:0] idle_cnt;
    logic [8:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic       tmr_tc, stop_sample, good_byte, start_seen, timeout;
    logic       push, push_ok, pop;
    logic [8:0] push_word;

    assign tmr_tc      = (bit_tmr == '0);
    assign stop_sample = (state == S_STOP) && tmr_tc;
    assign good_byte   = stop_sample && rxs;
    assign start_seen  = (state == S_IDLE) && !rxs;
    assign timeout     = pend_valid && (idle_cnt == IDLE_W'(IDLE_LIMIT));
    // A timeout closes the held byte as last; otherwise a new good byte releases it as non-last.
    assign push        = timeout || (good_byte && pend_valid);
    assign push_word   = {timeout, pend_data};
    assign pop         = m_axis_valid && m_axis_ready;
    assign push_ok     = push && ((fifo_count < (PTR_W + 1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_tmr <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state   <= S_START;
                        bit_tmr <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (tmr_tc) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_tmr <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_tmr <= bit_tmr - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tmr_tc) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_tmr <= FULL_LOAD;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_tmr <= bit_tmr - 1'b1;
                    end
                end
                default: begin
                    // Leave mid stop bit so the next start edge is not missed.
                    if (tmr_tc) state <= S_IDLE;
                    else        bit_tmr <= bit_tmr - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_valid <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (good_byte) begin
                pend_data  <= shift;
                pend_valid <= 1'b1;
            end else if (timeout) begin
                pend_valid <= 1'b0;
            end
            if (stop_sample || start_seen)
                idle_cnt <= '0;
            else if ((state == S_IDLE) && pend_valid && !timeout)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
            frame_err <= stop_sample && !rxs;
            overrun   <= push && !push_ok;
        end
    end

    assign m_axis_valid = (fifo_count != '0);
    assign m_axis_data  = m_axis_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign m_axis_last  = m_axis_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: a frame table plus hand sequences for latency,
// glitch rejection, backpressure/overrun and reset mid-frame.
module tb_uart_rx_axis;

    localparam int CPB        = 16;
    localparam int DEPTH      = 8;
    localparam int IDLE_BITS  = 20;
    localparam int IDLE_LIMIT = IDLE_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_last;
    logic       m_axis_ready;
    logic       frame_err;
    logic       overrun;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_rx_axis #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IDLE_BITS(IDLE_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_beat;
        logic       exp_last;
    } vec_t;

    vec_t vecs[8];

    int vectors_applied = 0;
    int miscompares     = 0;

    int cyc = 0;
    logic [8:0] beat_q[$];
    int         beat_cyc[$];
    int fe_cycles = 0, fe_rises = 0, ov_cycles = 0, ov_rises = 0;
    int max_count = 0, stall_err = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_axis_valid && m_axis_ready) begin
            beat_q.push_back({m_axis_last, m_axis_data});
            beat_cyc.push_back(cyc);
        end
        if (frame_err) fe_cycles++;
        if (frame_err && !fe_prev) fe_rises++;
        if (overrun) ov_cycles++;
        if (overrun && !ov_prev) ov_rises++;
        fe_prev = frame_err;
        ov_prev = overrun;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        if (prev_stall && m_axis_valid && (m_axis_data != prev_data || m_axis_last != prev_last))
            stall_err++;
        prev_stall = m_axis_valid && !m_axis_ready;
        prev_data  = m_axis_data;
        prev_last  = m_axis_last;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors_applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        uart_rx = 1'b1;
        tick(gap * CPB);
    endtask

    task automatic check_beats(input string name, input logic [8:0] exp_q[$]);
        check({name, "_count"}, beat_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i),
                  (i < beat_q.size()) ? int'(beat_q[i]) : -1, int'(exp_q[i]));
    endtask

    initial begin
        logic [8:0] exp_q[$];
        int n0, t0, lat, fe0, ov0, fc0;

        vecs[0] = '{8'hA5, 1'b1, 25, 1'b1, 1'b1};
        vecs[1] = '{8'h01, 1'b1,  0, 1'b1, 1'b0};
        vecs[2] = '{8'h02, 1'b1,  0, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 1'b1, 25, 1'b1, 1'b1};
        vecs[4] = '{8'h3C, 1'b0,  2, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 1'b1, 25, 1'b1, 1'b1};
        vecs[6] = '{8'hC3, 1'b1,  5, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 25, 1'b1, 1'b1};

        rst = 1'b1;
        uart_rx = 1'b1;
        m_axis_ready = 1'b1;
        tick(3);
        check("rst_valid", m_axis_valid, 0);
        check("rst_data", m_axis_data, 0);
        check("rst_last", m_axis_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        tick(3);

        // Single byte: the beat appears one idle timeout after the stop sample.
        beat_q.delete();
        beat_cyc.delete();
        send_frame(8'h96, 1'b1, 0);
        t0 = cyc;
        n0 = beat_q.size();
        for (int k = 0; k < IDLE_LIMIT + 4 * CPB && beat_q.size() == n0; k++) tick(1);
        check("lat_seen", beat_q.size() - n0, 1);
        lat = (beat_q.size() > n0) ? beat_cyc[n0] - t0 : -1;
        check("lat_window", int'(lat >= IDLE_LIMIT - CPB && lat <= IDLE_LIMIT + 2), 1);
        check("lat_beat", (beat_q.size() > n0) ? int'(beat_q[n0]) : -1, 9'h196);
        tick(5 * CPB);

        // Frame table: packets, back-to-back bytes, framing error, short gap.
        beat_q.delete();
        fe0 = fe_cycles;
        n0  = fe_rises;
        ov0 = ov_rises;
        for (int i = 0; i < 8; i++) send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap);
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            if (vecs[i].exp_beat) exp_q.push_back({vecs[i].exp_last, vecs[i].data});
        check_beats("table", exp_q);
        check("table_fe_pulses", fe_rises - n0, 1);
        check("table_fe_width", fe_cycles - fe0, 1);
        check("table_overrun", ov_rises - ov0, 0);

        // Glitch shorter than half a bit is ignored.
        beat_q.delete();
        fe0 = fe_rises;
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h7E, 1'b1, 25);
        exp_q.delete();
        exp_q.push_back(9'h17E);
        check_beats("glitch", exp_q);
        check("glitch_fe", fe_rises - fe0, 0);

        // Backpressure: 10 bytes into an 8-entry FIFO.
        m_axis_ready = 1'b0;
        tick(1);
        beat_q.delete();
        ov0 = ov_rises;
        fc0 = ov_cycles;
        max_count = 0;
        for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, (i == 9) ? 25 : 0);
        check("ovr_max_count", max_count, 8);
        check("ovr_count", fifo_count, 8);
        check("ovr_head_data", m_axis_data, 0);
        check("ovr_head_last", m_axis_last, 0);
        check("ovr_pulses", ov_rises - ov0, 2);
        check("ovr_width", ov_cycles - fc0, 2);
        check("ovr_no_beats", beat_q.size(), 0);
        m_axis_ready = 1'b1;
        tick(20);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'(i)});
        check_beats("drain", exp_q);
        check("drain_count", fifo_count, 0);

        // Reset during data bit 4 of 0x81 while the FIFO holds a byte.
        m_axis_ready = 1'b0;
        tick(1);
        send_frame(8'h11, 1'b1, 25);
        check("pre_rst_valid", m_axis_valid, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        uart_rx = 1'b0;
        tick(CPB / 2);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", m_axis_valid, 0);
        check("mid_rst_data", m_axis_data, 0);
        check("mid_rst_last", m_axis_last, 0);
        check("mid_rst_count", fifo_count, 0);
        tick(3);
        uart_rx = 1'b1;
        rst = 1'b0;
        tick(3 * CPB);
        m_axis_ready = 1'b1;
        beat_q.delete();
        send_frame(8'h5A, 1'b1, 25);
        exp_q.delete();
        exp_q.push_back(9'h15A);
        check_beats("post_rst", exp_q);

        check("stall_stable", stall_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
